// File: rtl/coprocessor0_control.sv
// MIPS-style CP0 control block: Status/Cause/EPC/BadVAddr/Count/Compare,
// exception and eret sequencing, timer interrupt and mfc0/mtc0 access.
module coprocessor0_control #(
    parameter logic [31:0] EXCEPTION_ENTRY = 32'hBFC0_0380
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_address_register,
    input  logic [2:0]  wb_address_select,
    input  logic        wb_write_enabled,
    input  logic [31:0] wb_write_data,
    input  logic        wb_exception_valid,
    input  logic [4:0]  wb_exception_code,
    input  logic        wb_in_delay_slot,
    input  logic [31:0] wb_exception_address,
    input  logic [31:0] wb_bad_vaddr,
    input  logic        wb_eret_flush,
    input  logic [5:0]  hardware_interrupt,
    input  logic [4:0]  read_register,
    input  logic [2:0]  read_select,
    output logic [31:0] read_data,
    output logic        interrupt_pending,
    output logic        flush,
    output logic [31:0] exception_pc
);

    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc_code;
    logic [31:0] epc;
    logic [31:0] bad_vaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic        tick;

    logic exception;
    logic eret;
    logic mtc0;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic [7:0]  ip;
    logic [31:0] status_word;
    logic [31:0] cause_word;

    assign exception = wb_valid & wb_exception_valid;
    assign eret      = wb_valid & wb_eret_flush & ~wb_exception_valid;
    // mtc0 loses to any exception or eret retiring in the same cycle
    assign mtc0 = wb_valid & wb_write_enabled
                & ~wb_exception_valid & ~wb_eret_flush
                & (wb_address_select == 3'd0);

    assign wr_count   = mtc0 & (wb_address_register == 5'd9);
    assign wr_compare = mtc0 & (wb_address_register == 5'd11);
    assign wr_status  = mtc0 & (wb_address_register == 5'd12);
    assign wr_cause   = mtc0 & (wb_address_register == 5'd13);
    assign wr_epc     = mtc0 & (wb_address_register == 5'd14);

    assign ip = {cause_ip_hw[5] | cause_ti, cause_ip_hw[4:0], cause_ip_sw};

    assign status_word = {9'd0, 1'b1, 6'd0, status_im, 6'd0,
                          status_exl, status_ie};
    assign cause_word  = {cause_bd, cause_ti, 14'd0, ip, 1'b0,
                          cause_exc_code, 2'd0};

    always_ff @(posedge clock) begin
        if (reset) begin
            status_im      <= 8'd0;
            status_exl     <= 1'b0;
            status_ie      <= 1'b0;
            cause_bd       <= 1'b0;
            cause_ti       <= 1'b0;
            cause_ip_hw    <= 6'd0;
            cause_ip_sw    <= 2'd0;
            cause_exc_code <= 5'd0;
            epc            <= 32'd0;
            bad_vaddr      <= 32'd0;
            count          <= 32'd0;
            compare        <= 32'd0;
            tick           <= 1'b0;
        end else begin
            tick        <= ~tick;
            cause_ip_hw <= hardware_interrupt;
            if (wr_count) begin
                count <= wb_write_data;
            end else if (tick) begin
                count <= count + 32'd1;
            end
            if (wr_compare) begin
                compare  <= wb_write_data;
                cause_ti <= 1'b0;
            end else if (count == compare) begin
                cause_ti <= 1'b1;
            end
            if (exception) begin
                if (!status_exl) begin
                    epc <= wb_in_delay_slot ? wb_exception_address - 32'd4
                                            : wb_exception_address;
                    cause_bd <= wb_in_delay_slot;
                end
                cause_exc_code <= wb_exception_code;
                status_exl     <= 1'b1;
                if (wb_exception_code == 5'd4 || wb_exception_code == 5'd5) begin
                    bad_vaddr <= wb_bad_vaddr;
                end
            end else if (eret) begin
                status_exl <= 1'b0;
            end else begin
                if (wr_status) begin
                    status_im  <= wb_write_data[15:8];
                    status_exl <= wb_write_data[1];
                    status_ie  <= wb_write_data[0];
                end
                if (wr_cause) begin
                    cause_ip_sw <= wb_write_data[9:8];
                end
                if (wr_epc) begin
                    epc <= wb_write_data;
                end
            end
        end
    end

    always_comb begin
        read_data = 32'd0;
        if (read_select == 3'd0) begin
            case (read_register)
                5'd8:    read_data = bad_vaddr;
                5'd9:    read_data = count;
                5'd11:   read_data = compare;
                5'd12:   read_data = status_word;
                5'd13:   read_data = cause_word;
                5'd14:   read_data = epc;
                default: read_data = 32'd0;
            endcase
        end
    end

    assign interrupt_pending = ~reset & status_ie & ~status_exl
                             & (|(status_im & ip));
    assign flush = ~reset & wb_valid & (wb_exception_valid | wb_eret_flush);

    always_comb begin
        exception_pc = 32'd0;
        if (exception) begin
            exception_pc = EXCEPTION_ENTRY;
        end else if (eret) begin
            exception_pc = epc;
        end
    end

endmodule

// File: tb/tb_coprocessor0_control.sv
// Bench for coprocessor0_control: directed scenarios followed by random
// traffic, all checked against a word-level reference model.
module tb_coprocessor0_control;

    localparam logic [31:0] ENTRY = 32'hBFC0_0380;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_address_register;
    logic [2:0]  wb_address_select;
    logic        wb_write_enabled;
    logic [31:0] wb_write_data;
    logic        wb_exception_valid;
    logic [4:0]  wb_exception_code;
    logic        wb_in_delay_slot;
    logic [31:0] wb_exception_address;
    logic [31:0] wb_bad_vaddr;
    logic        wb_eret_flush;
    logic [5:0]  hardware_interrupt;
    logic [4:0]  read_register;
    logic [2:0]  read_select;
    logic [31:0] read_data;
    logic        interrupt_pending;
    logic        flush;
    logic [31:0] exception_pc;

    int checks = 0;
    int errors = 0;

    coprocessor0_control #(.EXCEPTION_ENTRY(ENTRY)) dut (
        .clock(clock),
        .reset(reset),
        .wb_valid(wb_valid),
        .wb_address_register(wb_address_register),
        .wb_address_select(wb_address_select),
        .wb_write_enabled(wb_write_enabled),
        .wb_write_data(wb_write_data),
        .wb_exception_valid(wb_exception_valid),
        .wb_exception_code(wb_exception_code),
        .wb_in_delay_slot(wb_in_delay_slot),
        .wb_exception_address(wb_exception_address),
        .wb_bad_vaddr(wb_bad_vaddr),
        .wb_eret_flush(wb_eret_flush),
        .hardware_interrupt(hardware_interrupt),
        .read_register(read_register),
        .read_select(read_select),
        .read_data(read_data),
        .interrupt_pending(interrupt_pending),
        .flush(flush),
        .exception_pc(exception_pc)
    );

    always #10 clock = ~clock;

    // Reference model: whole architectural words, Cause IP[15] folded in on read
    logic [31:0] m_status, m_cause, m_epc, m_bad, m_count, m_compare;
    bit          m_half;
    bit          m_valid = 0;

    function automatic logic [31:0] m_cause_rd();
        logic [31:0] c;
        c = m_cause;
        c[15] = m_cause[15] | m_cause[30];
        return c;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r, input logic [2:0] s);
        if (s != 3'd0) return 32'd0;
        case (r)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause_rd();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_flush();
        return !reset && wb_valid && (wb_exception_valid || wb_eret_flush);
    endfunction

    function automatic logic [31:0] exp_pc();
        if (wb_valid && wb_exception_valid) return ENTRY;
        if (wb_valid && wb_eret_flush) return m_epc;
        return 32'd0;
    endfunction

    function automatic logic exp_ipend();
        logic [31:0] c;
        c = m_cause_rd();
        return !reset && m_status[0] && !m_status[1] && (|(m_status[15:8] & c[15:8]));
    endfunction

    task automatic model_update();
        bit exc, er, wr, ti;
        logic [31:0] nc;
        if (reset) begin
            m_status = 32'h0040_0000;
            m_cause = 0; m_epc = 0; m_bad = 0;
            m_count = 0; m_compare = 0; m_half = 0;
            m_valid = 1;
            return;
        end
        exc = wb_valid && wb_exception_valid;
        er  = wb_valid && wb_eret_flush && !exc;
        wr  = wb_valid && wb_write_enabled && !exc && !er && wb_address_select == 0;
        ti  = m_cause[30] || (m_count == m_compare);
        if (wr && wb_address_register == 11) ti = 0;
        nc = m_count + (m_half ? 32'd1 : 32'd0);
        if (wr && wb_address_register == 9) nc = wb_write_data;
        m_half = !m_half;
        m_cause[15:10] = hardware_interrupt;
        m_cause[30] = ti;
        if (exc) begin
            if (!m_status[1]) begin
                m_epc = wb_in_delay_slot ? wb_exception_address - 4 : wb_exception_address;
                m_cause[31] = wb_in_delay_slot;
            end
            m_cause[6:2] = wb_exception_code;
            m_status[1] = 1;
            if (wb_exception_code == 4 || wb_exception_code == 5) m_bad = wb_bad_vaddr;
        end else if (er) begin
            m_status[1] = 0;
        end else if (wr) begin
            case (wb_address_register)
                5'd11: m_compare = wb_write_data;
                5'd12: m_status = (wb_write_data & 32'h0000_FF03) | 32'h0040_0000;
                5'd13: m_cause = (m_cause & ~32'h300) | (wb_write_data & 32'h300);
                5'd14: m_epc = wb_write_data;
                default: ;
            endcase
        end
        m_count = nc;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        #1;
        if (m_valid) chk("read_data", read_data, m_read(read_register, read_select));
        chk("flush", {31'd0, flush}, {31'd0, exp_flush()});
        chk("exception_pc", exception_pc, exp_pc());
        chk("interrupt_pending", {31'd0, interrupt_pending}, {31'd0, exp_ipend()});
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic peek(input string tag, input logic [4:0] r,
                        input logic [31:0] mask, input logic [31:0] exp);
        read_register = r;
        read_select = 0;
        #1;
        chk(tag, read_data & mask, exp);
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_address_register = 0; wb_address_select = 0;
        wb_write_enabled = 0; wb_write_data = 0; wb_exception_valid = 0;
        wb_exception_code = 0; wb_in_delay_slot = 0; wb_exception_address = 0;
        wb_bad_vaddr = 0; wb_eret_flush = 0;
    endtask

    task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
        clear_wb();
        wb_valid = 1; wb_write_enabled = 1;
        wb_address_register = r; wb_write_data = d;
        step();
        clear_wb();
    endtask

    initial begin
        bit got;
        clear_wb();
        hardware_interrupt = 0;
        read_register = 12; read_select = 0;
        reset = 1;
        wb_valid = 1; wb_exception_valid = 1;
        repeat (3) step();
        clear_wb();
        reset = 0;

        peek("status_reset", 12, 32'hFFFF_FFFF, 32'h0040_0000);
        peek("cause_reset", 13, 32'hFFFF_FFFF, 32'h0);
        read_register = 9;
        repeat (10) step();
        peek("count_after_10", 9, 32'hFFFF_FFFF, 32'd5);

        wb_valid = 1; wb_exception_valid = 1; wb_exception_code = 4;
        wb_exception_address = 32'hBFC0_0100; wb_in_delay_slot = 1; wb_bad_vaddr = 32'h1;
        #1;
        chk("exc_flush", {31'd0, flush}, 32'd1);
        chk("exc_pc", exception_pc, 32'hBFC0_0380);
        step();
        clear_wb();
        peek("epc_ds", 14, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        peek("cause_bd_code", 13, 32'h8000_007C, 32'h8000_0010);
        peek("status_exl", 12, 32'h2, 32'h2);
        step();
        peek("badvaddr", 8, 32'hFFFF_FFFF, 32'h1);

        wb_valid = 1; wb_exception_valid = 1; wb_exception_code = 8;
        wb_exception_address = 32'h8000_1230; wb_bad_vaddr = 32'hDEAD_0000;
        step();
        clear_wb();
        peek("epc_nested", 14, 32'hFFFF_FFFF, 32'hBFC0_00FC);
        peek("cause_nested", 13, 32'h8000_007C, 32'h8000_0020);
        peek("badvaddr_kept", 8, 32'hFFFF_FFFF, 32'h1);
        wb_valid = 1; wb_eret_flush = 1;
        #1;
        chk("eret_pc", exception_pc, 32'hBFC0_00FC);
        step();
        clear_wb();
        peek("eret_exl", 12, 32'h2, 32'h0);

        mtc0(8, 32'h5555_AAAA);
        peek("badvaddr_ro", 8, 32'hFFFF_FFFF, 32'h1);
        mtc0(12, 32'h0000_8001);
        mtc0(11, m_count + 32'd4);
        peek("ti_cleared", 13, 32'h4000_0000, 32'h0);
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            step();
            read_register = 13;
            #1;
            got = read_data[30];
        end
        chk("ti_rise", {31'd0, got}, 32'd1);
        chk("ipend_timer", {31'd0, interrupt_pending}, 32'd1);
        mtc0(11, 32'hFFFF_0000);
        peek("ti_clear_wr", 13, 32'h4000_8000, 32'h0);
        chk("ipend_off", {31'd0, interrupt_pending}, 32'd0);

        mtc0(12, 32'h0000_0101);
        mtc0(13, 32'h0000_0100);
        #1;
        chk("ipend_sw", {31'd0, interrupt_pending}, 32'd1);
        wb_valid = 1; wb_exception_valid = 1; wb_exception_code = 0;
        wb_exception_address = 32'h8000_0040;
        wb_write_enabled = 1; wb_address_register = 14; wb_write_data = 32'h1234_5678;
        step();
        clear_wb();
        peek("epc_vs_mtc0", 14, 32'hFFFF_FFFF, 32'h8000_0040);
        wb_valid = 1; wb_eret_flush = 1;
        step();
        clear_wb();

        mtc0(9, 32'hFFFF_FFFF);
        read_register = 9;
        repeat (2) step();
        peek("count_wrap", 9, 32'hFFFF_FFFF, 32'h0);

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            hardware_interrupt = 6'($urandom);
            wb_valid = ($urandom_range(0, 9) < 7);
            wb_exception_valid = ($urandom_range(0, 9) == 0);
            wb_eret_flush = ($urandom_range(0, 9) == 0);
            wb_exception_code = ($urandom_range(0, 1) == 0) ? 5'(4 + $urandom_range(0, 1))
                                                            : 5'($urandom);
            wb_in_delay_slot = 1'($urandom);
            wb_exception_address = $urandom;
            wb_bad_vaddr = $urandom;
            wb_write_enabled = ($urandom_range(0, 9) < 4);
            case ($urandom_range(0, 7))
                0: wb_address_register = 8;
                1: wb_address_register = 9;
                2: wb_address_register = 11;
                3: wb_address_register = 12;
                4: wb_address_register = 13;
                5: wb_address_register = 14;
                default: wb_address_register = 5'($urandom);
            endcase
            wb_address_select = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            wb_write_data = ($urandom_range(0, 3) == 0) ? m_count + 32'($urandom_range(0, 6))
                                                       : $urandom;
            read_register = ($urandom_range(0, 1) == 0) ? 5'(8 + $urandom_range(0, 6))
                                                       : 5'($urandom);
            read_select = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/coprocessor0_control.md
COPROCESSOR0_CONTROL -- requirements
Module: coprocessor0_control

Interface
REQ-001 SHALL have parameter EXCEPTION_ENTRY, default 32'hBFC0_0380, the general exception vector driven on exception_pc.
REQ-002 SHALL have one clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-003 clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wb_valid  in  1  qualifies every wb_* input for this cycle.
REQ-006 wb_address_register  in  5; wb_address_select  in  3  target CP0 register for mtc0.
REQ-007 wb_write_enabled  in  1; wb_write_data  in  32  mtc0 request and data.
REQ-008 wb_exception_valid  in  1; wb_exception_code  in  5; wb_in_delay_slot  in  1; wb_exception_address  in  32  faulting instruction PC.
REQ-009 wb_bad_vaddr  in  32  faulting data or fetch address for AdEL/AdES.
REQ-010 wb_eret_flush  in  1  eret retiring.
REQ-011 hardware_interrupt  in  6  level-sensitive external interrupt lines.
REQ-012 read_register  in  5; read_select  in  3; read_data  out  32  mfc0 read port.
REQ-013 interrupt_pending  out  1  the ID stage tags the next instruction with ExcCode 0 (Int).
REQ-014 flush  out  1; exception_pc  out  32  pipeline flush and redirect target for IF.

Function
REQ-015 SHALL implement these registers (reg,sel): BadVAddr (8,0), Count (9,0), Compare (11,0), Status (12,0), Cause (13,0), EPC (14,0); any other address reads 0 and ignores writes.
REQ-016 Status writable fields: IM[15:8], EXL[1], IE[0]; BEV[22] reads constant 1; all other bits read 0.
REQ-017 Cause writable fields: IP[9:8] (software interrupts) only. BD[31], TI[30], IP[15:10] and ExcCode[6:2] are hardware-owned.
REQ-018 EPC, Compare and Count are fully writable; BadVAddr is read-only via mtc0.
REQ-019 read_data SHALL be combinational from the current register state, with no same-cycle write bypass.
REQ-020 Cause.IP[15:10] SHALL register hardware_interrupt each cycle; IP[15] = hardware_interrupt[5] OR TI.
REQ-021 interrupt_pending = IE AND NOT EXL AND OR(IM AND IP[15:8]), combinational from registered state.
REQ-022 Count SHALL increment by 1 every second cycle, driven by a 1-bit tick toggle that flips every cycle. Count wraps 32'hFFFF_FFFF -> 0.
REQ-023 An mtc0 to Count SHALL load wb_write_data, overriding that cycle's increment; the tick toggle is unaffected.
REQ-024 TI SHALL set on the cycle after registered Count equals Compare and SHALL hold until cleared.
REQ-025 An mtc0 to Compare SHALL clear TI in the same edge; the clear wins over a simultaneous set.
REQ-026 Exception (wb_valid AND wb_exception_valid), when EXL=0: EPC <= wb_in_delay_slot ? wb_exception_address-4 : wb_exception_address; BD <= wb_in_delay_slot.
REQ-027 Exception when EXL=1: EPC and BD unchanged.
REQ-028 Exception in all cases: ExcCode <= wb_exception_code; EXL <= 1.
REQ-029 Exception with ExcCode 4 (AdEL) or 5 (AdES): BadVAddr <= wb_bad_vaddr.
REQ-030 Eret (wb_valid AND wb_eret_flush, no exception): EXL <= 0.
REQ-031 flush = wb_valid AND (wb_exception_valid OR wb_eret_flush), combinational.
REQ-032 exception_pc = EXCEPTION_ENTRY on exception, else the current registered EPC on eret, else 0.
REQ-033 Priority: exception > eret > mtc0. An mtc0 in the same cycle as an exception or eret SHALL be discarded.
REQ-034 All wb_* inputs SHALL be ignored when wb_valid=0.

Reset
REQ-035 On reset: Status=32'h0040_0000, Cause=0, EPC=0, BadVAddr=0, Count=0, Compare=0, tick=0.
REQ-036 During reset: flush=0 and interrupt_pending=0; reset overrides every simultaneous wb request.

Verification
REQ-037 Reset, then read (12,0) and (13,0) -> 32'h0040_0000 and 0; hold 10 cycles -> Count=5.
REQ-038 Exception code 4, PC 32'hBFC0_0100, delay slot=1, bad_vaddr 32'h1 -> same cycle flush=1 and exception_pc=32'hBFC0_0380. Next cycle: EPC=32'hBFC0_00FC, BD=1, ExcCode=4, EXL=1, BadVAddr=1.
REQ-039 Second exception (code 8) while EXL=1 -> EPC and BD unchanged, ExcCode=8. Then eret -> exception_pc=EPC and EXL=0.
REQ-040 Write Status=32'h0000_8001, then Compare=Count+4 -> TI and interrupt_pending rise within about 9 cycles. Write Compare -> TI clears on the next edge.
REQ-041 Write Cause=32'h0000_0100 with Status IM[8]=1 and IE=1 -> interrupt_pending=1. A simultaneous exception and mtc0 to EPC -> EPC takes the exception value, not the mtc0 value.
